// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM two-port arbiter: FSM encoding, port IDs and default widths.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF = 27;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_e;

endpackage

// File: rtl/sdram_arb_port.sv
// One requester port: a single pending slot plus the registered read-data/done outputs.
module sdram_arb_port
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              we,
  input  logic              busy,
  input  logic              grant,
  input  logic              complete,
  input  logic [DATA_W-1:0] q_in,
  output logic              ready,
  output logic              pend,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_data,
  output logic              slot_we,
  output logic [DATA_W-1:0] q,
  output logic              done
);

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;

  // Handshake: a request is taken when start && ready at a rising edge; a start
  // while ready is low is dropped and never produces a done.
  assign ready = !pend_q && !busy;

  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    done_d  = complete;
    if (grant) pend_d = 1'b0;
    if (start && ready) begin
      pend_d = 1'b1;
      addr_d = addr;
      data_d = data;
      we_d   = we;
    end
    if (complete) rdata_d = q_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  assign pend      = pend_q;
  assign slot_addr = addr_q;
  assign slot_data = data_q;
  assign slot_we   = we_q;
  assign q         = rdata_q;
  assign done      = done_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between the I-side and D-side miss buses.
// D has fixed priority, bounded by MAX_D_RUN consecutive grants while I waits.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_D_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] bus_i_addr,
  input  logic [DATA_W-1:0] bus_i_data,
  input  logic              bus_i_we,
  input  logic              bus_i_start,
  output logic [DATA_W-1:0] bus_i_q,
  output logic              bus_i_done,
  output logic              bus_i_ready,
  input  logic [ADDR_W-1:0] bus_d_addr,
  input  logic [DATA_W-1:0] bus_d_data,
  input  logic              bus_d_we,
  input  logic              bus_d_start,
  output logic [DATA_W-1:0] bus_d_q,
  output logic              bus_d_done,
  output logic              bus_d_ready,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_data,
  output logic              ctrl_we,
  output logic              ctrl_start,
  input  logic [DATA_W-1:0] ctrl_q,
  input  logic              ctrl_done,
  input  logic              ctrl_ready,
  output logic [1:0]        dbg_state
);

  localparam logic [3:0] MAX_RUN = MAX_D_RUN[3:0];

  arb_state_e        state_q, state_d;
  port_id_e          owner_q, owner_d;
  logic [3:0]        d_run_q, d_run_d;
  logic [ADDR_W-1:0] ctrl_addr_q, ctrl_addr_d;
  logic [DATA_W-1:0] ctrl_data_q, ctrl_data_d;
  logic              ctrl_we_q, ctrl_we_d;
  logic              ctrl_start_q, ctrl_start_d;

  logic              pend_i, pend_d, we_i, we_d;
  logic [ADDR_W-1:0] addr_i, addr_d;
  logic [DATA_W-1:0] data_i, data_d;
  logic              grant_i, grant_d, cmpl_i, cmpl_d, busy_i, busy_d, d_wins;

  assign busy_i = (owner_q == PORT_I) && (state_q != IDLE);
  assign busy_d = (owner_q == PORT_D) && (state_q != IDLE);
  assign d_wins = pend_d && (!pend_i || (d_run_q < MAX_RUN));

  sdram_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port_i (
    .clk(clk), .reset(reset), .start(bus_i_start), .addr(bus_i_addr), .data(bus_i_data),
    .we(bus_i_we), .busy(busy_i), .grant(grant_i), .complete(cmpl_i), .q_in(ctrl_q),
    .ready(bus_i_ready), .pend(pend_i), .slot_addr(addr_i), .slot_data(data_i),
    .slot_we(we_i), .q(bus_i_q), .done(bus_i_done)
  );

  sdram_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port_d (
    .clk(clk), .reset(reset), .start(bus_d_start), .addr(bus_d_addr), .data(bus_d_data),
    .we(bus_d_we), .busy(busy_d), .grant(grant_d), .complete(cmpl_d), .q_in(ctrl_q),
    .ready(bus_d_ready), .pend(pend_d), .slot_addr(addr_d), .slot_data(data_d),
    .slot_we(we_d), .q(bus_d_q), .done(bus_d_done)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ctrl_addr_d  = ctrl_addr_q;
    ctrl_data_d  = ctrl_data_q;
    ctrl_we_d    = ctrl_we_q;
    ctrl_start_d = 1'b0;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    cmpl_i       = 1'b0;
    cmpl_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_ready && (pend_i || pend_d)) begin
          if (d_wins) begin
            grant_d     = 1'b1;
            owner_d     = PORT_D;
            ctrl_addr_d = addr_d;
            ctrl_data_d = data_d;
            ctrl_we_d   = we_d;
          end else begin
            grant_i     = 1'b1;
            owner_d     = PORT_I;
            ctrl_addr_d = addr_i;
            ctrl_data_d = data_i;
            ctrl_we_d   = we_i;
          end
          ctrl_start_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ctrl_done) begin
          cmpl_i  = (owner_q == PORT_I);
          cmpl_d  = (owner_q == PORT_D);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Run length of D grants that jumped a waiting I request.
  always_comb begin
    d_run_d = d_run_q;
    if (grant_d && pend_i) begin
      if (d_run_q != MAX_RUN) d_run_d = d_run_q + 4'd1;
    end else if (grant_i || !pend_i) begin
      d_run_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= PORT_I;
      d_run_q      <= 4'd0;
      ctrl_addr_q  <= '0;
      ctrl_data_q  <= '0;
      ctrl_we_q    <= 1'b0;
      ctrl_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      d_run_q      <= d_run_d;
      ctrl_addr_q  <= ctrl_addr_d;
      ctrl_data_q  <= ctrl_data_d;
      ctrl_we_q    <= ctrl_we_d;
      ctrl_start_q <= ctrl_start_d;
    end
  end

  assign ctrl_addr  = ctrl_addr_q;
  assign ctrl_data  = ctrl_data_q;
  assign ctrl_we    = ctrl_we_q;
  assign ctrl_start = ctrl_start_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a behavioural SDRAM controller and queue scoreboards.
module tb_sdram_arbiter;

  localparam int AW  = 27;
  localparam int DW  = 32;
  localparam int CW  = AW + DW + 1;
  localparam int LAT = 5;

  logic          clk, reset;
  logic [AW-1:0] bus_i_addr, bus_d_addr, ctrl_addr;
  logic [DW-1:0] bus_i_data, bus_d_data, ctrl_data;
  logic          bus_i_we, bus_d_we, ctrl_we;
  logic          bus_i_start, bus_d_start, ctrl_start;
  logic [DW-1:0] bus_i_q, bus_d_q, ctrl_q;
  logic          bus_i_done, bus_d_done, bus_i_ready, bus_d_ready;
  logic          ctrl_done, ctrl_ready, model_rdy, force_nr;
  logic [1:0]    dbg_state;

  logic [CW-1:0] exp_ctrl_q[$];
  logic [DW-1:0] exp_i_q[$];
  logic [DW-1:0] exp_d_q[$];

  int chk_cnt, pass_cnt;
  int n_start, n_done_i, n_done_d;
  logic last_ctrl_done;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .bus_i_addr(bus_i_addr), .bus_i_data(bus_i_data), .bus_i_we(bus_i_we),
    .bus_i_start(bus_i_start), .bus_i_q(bus_i_q), .bus_i_done(bus_i_done),
    .bus_i_ready(bus_i_ready),
    .bus_d_addr(bus_d_addr), .bus_d_data(bus_d_data), .bus_d_we(bus_d_we),
    .bus_d_start(bus_d_start), .bus_d_q(bus_d_q), .bus_d_done(bus_d_done),
    .bus_d_ready(bus_d_ready),
    .ctrl_addr(ctrl_addr), .ctrl_data(ctrl_data), .ctrl_we(ctrl_we),
    .ctrl_start(ctrl_start), .ctrl_q(ctrl_q), .ctrl_done(ctrl_done),
    .ctrl_ready(ctrl_ready), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctrl_ready = model_rdy && !force_nr;

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    chk_cnt++;
    $display("FAIL %s: event seen/missing, required the opposite", name);
  endtask

  function automatic logic [DW-1:0] resp(input logic [AW-1:0] a);
    if (a == 27'h100) return 32'hDEADBEEF;
    return 32'hC0DE0000 ^ {5'b0, a};
  endfunction

  // ---------------- controller model ----------------
  initial begin : ctrl_model
    int cnt, hold;
    logic [AW-1:0] cur;
    cnt = 0; hold = 0; cur = '0;
    model_rdy = 1'b1; ctrl_done = 1'b0; ctrl_q = '0;
    forever begin
      @(negedge clk);
      ctrl_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ctrl_done = 1'b1;
          ctrl_q    = resp(cur);
          hold      = 2;
        end
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) model_rdy = 1'b1;
      end
      if (ctrl_start) begin
        cnt = LAT; cur = ctrl_addr; model_rdy = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) last_ctrl_done = ctrl_done;

  always @(negedge clk) begin
    if (reset) begin
      if (ctrl_start) begin
        n_start++;
        if (exp_ctrl_q.size() == 0) note_fail("ctrl_start_unexpected");
        else check("ctrl_req", 64'({ctrl_addr, ctrl_data, ctrl_we}), 64'(exp_ctrl_q.pop_front()));
      end
      if (bus_i_done) begin
        n_done_i++;
        if (exp_i_q.size() == 0) note_fail("bus_i_done_unexpected");
        else check("bus_i_q", 64'(bus_i_q), 64'(exp_i_q.pop_front()));
        check("bus_i_done_latency", 64'(last_ctrl_done), 64'd1);
        check("bus_i_ready_at_done", 64'(bus_i_ready), 64'd1);
        check("state_idle_at_i_done", 64'(dbg_state), 64'd0);
      end
      if (bus_d_done) begin
        n_done_d++;
        if (exp_d_q.size() == 0) note_fail("bus_d_done_unexpected");
        else check("bus_d_q", 64'(bus_d_q), 64'(exp_d_q.pop_front()));
        check("bus_d_done_latency", 64'(last_ctrl_done), 64'd1);
        check("bus_d_ready_at_done", 64'(bus_d_ready), 64'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_i(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                       input logic [DW-1:0] q_exp);
    bus_i_addr = a; bus_i_data = d; bus_i_we = w; bus_i_start = 1'b1;
    exp_i_q.push_back(q_exp);
  endtask

  task automatic set_d(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                       input logic [DW-1:0] q_exp);
    bus_d_addr = a; bus_d_data = d; bus_d_we = w; bus_d_start = 1'b1;
    exp_d_q.push_back(q_exp);
  endtask

  task automatic exp_ctrl(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    exp_ctrl_q.push_back({a, d, w});
  endtask

  task automatic tick();
    @(negedge clk);
    bus_i_start = 1'b0;
    bus_d_start = 1'b0;
  endtask

  task automatic drain(input string name);
    bit empty;
    empty = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (exp_ctrl_q.size() == 0 && exp_i_q.size() == 0 && exp_d_q.size() == 0) begin
        empty = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!empty) note_fail(name);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_d_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus_d_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    bit seen;
    int s0, di0;
    chk_cnt = 0; pass_cnt = 0; n_start = 0; n_done_i = 0; n_done_d = 0;
    last_ctrl_done = 1'b0; force_nr = 1'b0;
    reset = 1'b0;
    bus_i_addr = '0; bus_i_data = '0; bus_i_we = 1'b0; bus_i_start = 1'b0;
    bus_d_addr = '0; bus_d_data = '0; bus_d_we = 1'b0; bus_d_start = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_i_ready", 64'(bus_i_ready), 64'd1);
    check("rst_d_ready", 64'(bus_d_ready), 64'd1);
    check("rst_ctrl_start", 64'(ctrl_start), 64'd0);
    check("rst_ctrl_addr", 64'(ctrl_addr), 64'd0);
    check("rst_ctrl_data", 64'(ctrl_data), 64'd0);
    check("rst_ctrl_we", 64'(ctrl_we), 64'd0);
    check("rst_i_q", 64'(bus_i_q), 64'd0);
    check("rst_d_q", 64'(bus_d_q), 64'd0);
    check("rst_i_done", 64'(bus_i_done), 64'd0);
    check("rst_d_done", 64'(bus_d_done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single I read, timing of ctrl_start
    exp_ctrl(27'h100, 32'h0, 1'b0);
    set_i(27'h100, 32'h0, 1'b0, 32'hDEADBEEF);
    tick();
    check("t1_i_ready_low", 64'(bus_i_ready), 64'd0);
    check("t1_no_early_start", 64'(ctrl_start), 64'd0);
    @(negedge clk);
    check("t1_start_at_t2", 64'(ctrl_start), 64'd1);
    drain("t1_timeout");

    // simultaneous I read and D write: D first
    exp_ctrl(27'h20, 32'h12345678, 1'b1);
    exp_ctrl(27'h10, 32'h0, 1'b0);
    set_i(27'h10, 32'h0, 1'b0, 32'hC0DE0010);
    set_d(27'h20, 32'h12345678, 1'b1, 32'hC0DE0020);
    tick();
    drain("t2_timeout");

    // D keeps re-requesting while I waits: 4 D, 1 I, then D
    for (int k = 0; k < 4; k++) exp_ctrl(27'h40 + 27'(k), 32'h0, 1'b0);
    exp_ctrl(27'h30, 32'h0, 1'b0);
    exp_ctrl(27'h44, 32'h0, 1'b0);
    exp_ctrl(27'h45, 32'h0, 1'b0);
    set_i(27'h30, 32'h0, 1'b0, 32'hC0DE0030);
    set_d(27'h40, 32'h0, 1'b0, 32'hC0DE0040);
    tick();
    for (int k = 1; k < 6; k++) begin
      wait_d_done(seen);
      if (!seen) begin
        note_fail("t3_d_done_timeout");
        break;
      end
      check("t3_d_ready_after_done", 64'(bus_d_ready), 64'd1);
      set_d(27'h40 + 27'(k), 32'h0, 1'b0, 32'hC0DE0040 ^ 32'(k));
      tick();
    end
    drain("t3_timeout");

    // start while not ready is dropped
    #1 s0 = n_start; di0 = n_done_d;
    @(negedge clk);
    exp_ctrl(27'h50, 32'h0, 1'b0);
    set_d(27'h50, 32'h0, 1'b0, 32'hC0DE0050);
    tick();
    check("t4_d_ready_low", 64'(bus_d_ready), 64'd0);
    bus_d_addr = 27'h51; bus_d_start = 1'b1;
    tick();
    drain("t4_timeout");
    #1;
    check("t4_one_start", 64'(n_start - s0), 64'd1);
    check("t4_one_done", 64'(n_done_d - di0), 64'd1);

    // reset while waiting on the controller
    @(negedge clk);
    exp_ctrl(27'h60, 32'h0, 1'b0);
    set_i(27'h60, 32'h0, 1'b0, 32'hC0DE0060);
    tick();
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (ctrl_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) note_fail("t5_start_timeout");
    repeat (3) @(negedge clk);
    check("t5_in_wait", 64'(dbg_state), 64'd2);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_state", 64'(dbg_state), 64'd0);
    check("t5_rst_i_ready", 64'(bus_i_ready), 64'd1);
    check("t5_rst_ctrl_addr", 64'(ctrl_addr), 64'd0);
    check("t5_rst_i_q", 64'(bus_i_q), 64'd0);
    check("t5_rst_d_q", 64'(bus_d_q), 64'd0);
    exp_i_q.delete();
    s0 = n_start; di0 = n_done_i;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("t5_no_start_after_rst", 64'(n_start - s0), 64'd0);
    check("t5_no_done_after_rst", 64'(n_done_i - di0), 64'd0);
    check("t5_i_q_held", 64'(bus_i_q), 64'd0);
    check("t5_state_idle", 64'(dbg_state), 64'd0);

    // controller busy for 10 cycles with D pending
    @(negedge clk);
    force_nr = 1'b1;
    exp_ctrl(27'h70, 32'h0, 1'b0);
    set_d(27'h70, 32'h0, 1'b0, 32'hC0DE0070);
    tick();
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (ctrl_start) seen = 1'b1;
      @(negedge clk);
    end
    check("t6_no_start_while_busy", 64'(seen), 64'd0);
    force_nr = 1'b0;
    @(negedge clk);
    check("t6_start_after_ready", 64'(ctrl_start), 64'd1);
    @(negedge clk);
    check("t6_start_single_cycle", 64'(ctrl_start), 64'd0);
    drain("t6_timeout");

    #1;
    check("total_ctrl_starts", 64'(n_start), 64'd13);
    check("total_i_done", 64'(n_done_i), 64'd3);
    check("total_d_done", 64'(n_done_d), 64'd9);
    check("ctrl_queue_empty", 64'(exp_ctrl_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
